// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with M/W operand forwarding and load-use hazard detection.
// Holds the decoded instruction for execute; bubbles on flush, holds on stall.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic            EnE,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [4:0]      RdM,
  input  logic            RegWriteM,
  input  logic [XLEN-1:0] ResultW,
  input  logic [4:0]      RdW,
  input  logic            RegWriteW,
  output logic [XLEN-1:0] SrcAE,
  output logic [XLEN-1:0] SrcBE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] ImmExtE,
  output logic [2:0]      ALUControlE,
  output logic [1:0]      ResultSrcE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            ValidE,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic            LoadUseStallD
);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic            valid;
  } ex_t;

  ex_t             ex_d;
  ex_t             ex_q;
  logic [XLEN-1:0] fwd_a_s;
  logic [XLEN-1:0] fwd_b_s;

  // Memory stage wins over writeback; x0 is never a forwarding target.
  function automatic logic [XLEN-1:0] forward(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] reg_val,
    input logic [XLEN-1:0] m_val,
    input logic [4:0]      m_rd,
    input logic            m_we,
    input logic [XLEN-1:0] w_val,
    input logic [4:0]      w_rd,
    input logic            w_we
  );
    logic [XLEN-1:0] res;
    if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
      res = m_val;
    end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
      res = w_val;
    end else begin
      res = reg_val;
    end
    return res;
  endfunction

  // Next execute-register contents: bubble on flush, load when enabled, else hold.
  always_comb begin
    ex_d = ex_q;
    if (FlushE) begin
      ex_d = '0;
    end else if (EnE) begin
      ex_d.rd1         = RD1D;
      ex_d.rd2         = RD2D;
      ex_d.imm         = ImmExtD;
      ex_d.pc          = PCD;
      ex_d.rs1         = Rs1D;
      ex_d.rs2         = Rs2D;
      ex_d.rd          = RdD;
      ex_d.reg_write   = RegWriteD;
      ex_d.mem_write   = MemWriteD;
      ex_d.branch      = BranchD;
      ex_d.jump        = JumpD;
      ex_d.alu_src     = ALUSrcD;
      ex_d.result_src  = ResultSrcD;
      ex_d.alu_control = ALUControlD;
      ex_d.valid       = 1'b1;
    end else begin
      ex_d = ex_q;
    end
  end

  // Execute register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Operand forwarding and B-operand immediate select.
  always_comb begin
    fwd_a_s = forward(ex_q.rs1, ex_q.rd1, ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW);
    fwd_b_s = forward(ex_q.rs2, ex_q.rd2, ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW);
    if (ex_q.alu_src) begin
      SrcBE = ex_q.imm;
    end else begin
      SrcBE = fwd_b_s;
    end
  end

  // A load in execute whose destination feeds the decode instruction must stall decode.
  always_comb begin
    if ((ex_q.result_src == 2'b01) && ex_q.valid && (ex_q.rd != 5'd0) &&
        ((ex_q.rd == Rs1D) || (ex_q.rd == Rs2D))) begin
      LoadUseStallD = 1'b1;
    end else begin
      LoadUseStallD = 1'b0;
    end
  end

  assign SrcAE       = fwd_a_s;
  assign WriteDataE  = fwd_b_s;
  assign PCE         = ex_q.pc;
  assign ImmExtE     = ex_q.imm;
  assign ALUControlE = ex_q.alu_control;
  assign ResultSrcE  = ex_q.result_src;
  assign RegWriteE   = ex_q.reg_write;
  assign MemWriteE   = ex_q.mem_write;
  assign BranchE     = ex_q.branch;
  assign JumpE       = ex_q.jump;
  assign ValidE      = ex_q.valid;
  assign RdE         = ex_q.rd;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of all operand/PC/immediate buses.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port FlushE  input  1  high: load a bubble into the execute register on the next edge.
REQ-005 SHALL have port EnE  input  1  low: hold execute register contents (stall).
REQ-006 SHALL have ports RD1D, RD2D, ImmExtD, PCD  input  XLEN each  decode-stage register operands, extended immediate, PC.
REQ-007 SHALL have ports Rs1D, Rs2D, RdD  input  5 each  decode-stage source/destination register indices.
REQ-008 SHALL have ports RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD  input  1 each; ResultSrcD  input  2; ALUControlD  input  3  decode control.
REQ-009 SHALL have ports ALUResultM  input  XLEN, RdM  input  5, RegWriteM  input  1  memory-stage forwarding source.
REQ-010 SHALL have ports ResultW  input  XLEN, RdW  input  5, RegWriteW  input  1  writeback-stage forwarding source.
REQ-011 SHALL have ports SrcAE, SrcBE  output  XLEN  ALU operands A and B.
REQ-012 SHALL have ports WriteDataE, PCE, ImmExtE  output  XLEN  forwarded store data, PC, immediate.
REQ-013 SHALL have ports ALUControlE  output  3; ResultSrcE  output  2; RegWriteE, MemWriteE, BranchE, JumpE, ValidE  output  1; RdE, Rs1E, Rs2E  output  5  registered execute control/indices.
REQ-014 SHALL have port LoadUseStallD  output  1  high: decode must stall (load-use hazard).

Function
REQ-015 SHALL register all D inputs into their E counterparts on each rising edge when EnE=1 and FlushE=0; latency exactly one cycle.
REQ-016 SHALL, when FlushE=1, load zero into every E register (bubble) and set ValidE=0, regardless of EnE.
REQ-017 SHALL, when EnE=0 and FlushE=0, hold every E register unchanged.
REQ-018 SHALL set ValidE=1 on any non-flush load, 0 after reset or flush.
REQ-019 SHALL select forward A: ALUResultM if RegWriteM=1, RdM!=0, RdM==Rs1E; else ResultW if RegWriteW=1, RdW!=0, RdW==Rs1E; else registered RD1E.
REQ-020 SHALL select forward B by the same rule using Rs2E and RD2E; memory stage has priority over writeback when both match.
REQ-021 SHALL never forward for index x0; register x0 source yields registered value unchanged.
REQ-022 SHALL drive SrcAE = forward A; WriteDataE = forward B; SrcBE = ImmExtE if ALUSrcE=1 else forward B (combinational).
REQ-023 SHALL drive LoadUseStallD = 1 iff ResultSrcE==2'b01, ValidE=1, RdE!=0 and (RdE==Rs1D or RdE==Rs2D); combinational.
REQ-024 SHALL pass ALUControlE unchanged to the ALU (000 add, 001 sub, 010 and, 011 or, 101 slt).

Reset
REQ-025 SHALL, on reset=1, immediately (without clk) clear all E registers to zero and ValidE to 0; reset overrides FlushE and EnE.
REQ-026 SHALL, with reset held, drive SrcAE=SrcBE=WriteDataE=0 and LoadUseStallD=0 provided M/W forwarding inputs do not match index 0.
REQ-027 SHALL resume normal loading on the first rising edge after reset deasserts.

Verification
REQ-028 Pass-through: RD1D=5, RD2D=7, Rs1D=1, Rs2D=2, ALUSrcD=0, no M/W writes, one edge -> SrcAE=5, SrcBE=7, ValidE=1.
REQ-029 Forward priority: Rs1E=3, RdM=3, RegWriteM=1, ALUResultM=0x10, RdW=3, RegWriteW=1, ResultW=0x20 -> SrcAE=0x10; drop RegWriteM -> 0x20.
REQ-030 x0 guard: Rs2E=0, RdM=0, RegWriteM=1, ALUResultM=0xFF, RD2E=0 -> WriteDataE=0.
REQ-031 Stall/flush: EnE=0 for 3 edges with changing D inputs -> E outputs constant; FlushE=1 with EnE=0 -> RegWriteE=0, ValidE=0, all buses 0.
REQ-032 Load-use: ResultSrcE=01, RdE=4, ValidE=1, Rs2D=4 -> LoadUseStallD=1; RdE=0 -> 0.
REQ-033 Async reset mid-operation: assert reset between edges with ValidE=1 -> outputs zero before next edge; deassert -> next edge loads D inputs.
